// File: rtl/bcd_pkg.sv
// Shared BCD definitions: display code points, conversion FSM states and the
// double-dabble digit correction.
package bcd_pkg;

    localparam logic [3:0] BCD_MINUS = 4'hA;
    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    // A digit of 5 or more would exceed 9 once doubled, so pre-add 3.
    function automatic logic [3:0] dd_adjust(input logic [3:0] nibble);
        return (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
    endfunction

endpackage

// File: rtl/bcd_window_mux.sv
// Selects DISP_DIGITS consecutive digits of the committed BCD result,
// starting at digit win_off, for the seven-segment multiplexer.
module bcd_window_mux #(
    parameter int unsigned DIGITS      = 5,
    parameter int unsigned DISP_DIGITS = 4,
    parameter int unsigned OFF_W       = 2
) (
    input  logic [4*(DIGITS+1)-1:0] bcd,
    input  logic [OFF_W-1:0]        win_off,
    output logic [4*DISP_DIGITS-1:0] disp
);

    always_comb begin
        disp = '0;
        for (int i = 0; i < int'(DISP_DIGITS); i++) begin
            disp[4*i +: 4] = bcd[4*(int'(win_off) + i) +: 4];
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (one bit per clock) with a registered signed
// result and a saturating scroll window over the digits.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int unsigned BIN_W       = 16,
    parameter int unsigned DIGITS      = 5,
    parameter int unsigned DISP_DIGITS = 4,
    localparam int unsigned MAX_OFF    = DIGITS + 1 - DISP_DIGITS,
    localparam int unsigned OFF_W      = (MAX_OFF > 0) ? $clog2(MAX_OFF + 1) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin_in,
    input  logic                      sign_neg,
    input  logic                      scroll_up,
    input  logic                      scroll_dn,
    output logic                      busy,
    output logic                      done,
    output logic [4*(DIGITS+1)-1:0]   bcd_out,
    output logic [4*DISP_DIGITS-1:0]  disp_out,
    output logic [OFF_W-1:0]          win_off
);

    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [BIN_W-1:0]       bin_sr;
    logic [4*DIGITS-1:0]    bcd_sr;
    logic [4*DIGITS-1:0]    bcd_adj;
    logic                   sign_q;

    always_comb begin
        bcd_adj = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            bcd_adj[4*i +: 4] = dd_adjust(bcd_sr[4*i +: 4]);
        end
    end

    // bcd_out is written only in DONE, so a running conversion never disturbs it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bin_sr  <= '0;
            bcd_sr  <= '0;
            sign_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_out <= {BCD_BLANK, {(4*DIGITS){1'b0}}};
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr <= bin_in;
                        sign_q <= sign_neg;
                        bcd_sr <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_sr <= {bcd_adj[4*DIGITS-2:0], bin_sr[BIN_W-1]};
                    bin_sr <= {bin_sr[BIN_W-2:0], 1'b0};
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(BIN_W - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Negative zero shows a blank sign.
                    bcd_out <= {(sign_q && (bcd_sr != '0)) ? BCD_MINUS : BCD_BLANK, bcd_sr};
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_off <= '0;
        end else if (scroll_up && !scroll_dn && (win_off != OFF_W'(MAX_OFF))) begin
            win_off <= win_off + 1'b1;
        end else if (scroll_dn && !scroll_up && (win_off != '0)) begin
            win_off <= win_off - 1'b1;
        end
    end

    bcd_window_mux #(
        .DIGITS      (DIGITS),
        .DISP_DIGITS (DISP_DIGITS),
        .OFF_W       (OFF_W)
    ) u_window_mux (
        .bcd     (bcd_out),
        .win_off (win_off),
        .disp    (disp_out)
    );

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 16/5/4 instance and an 8/3/2 instance, both checked
// every cycle against a cycle-counting arithmetic model of the converter.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  st = '0, up = '0, dn = '0, ng = '0;
    logic [15:0] bin_a = '0;
    logic [7:0]  bin_b = '0;

    logic        busy_a, done_a, busy_b, done_b;
    logic [23:0] bcd_a;
    logic [15:0] disp_a, bcd_b;
    logic [7:0]  disp_b;
    logic [1:0]  off_a, off_b;

    int checks = 0;
    int errors = 0;
    int dcount[2] = '{0, 0};

    int BW[2] = '{16, 8};
    int DG[2] = '{5, 3};
    int DD[2] = '{4, 2};
    int MO[2] = '{2, 2};

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .DISP_DIGITS(4)) dut_a (
        .clk(clk), .rst(rst), .start(st[0]), .bin_in(bin_a), .sign_neg(ng[0]),
        .scroll_up(up[0]), .scroll_dn(dn[0]), .busy(busy_a), .done(done_a),
        .bcd_out(bcd_a), .disp_out(disp_a), .win_off(off_a)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3), .DISP_DIGITS(2)) dut_b (
        .clk(clk), .rst(rst), .start(st[1]), .bin_in(bin_b), .sign_neg(ng[1]),
        .scroll_up(up[1]), .scroll_dn(dn[1]), .busy(busy_b), .done(done_b),
        .bcd_out(bcd_b), .disp_out(disp_b), .win_off(off_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] to_bcd(input int v, input bit neg, input int d);
        logic [23:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < d; k++) begin
            r[4*k +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        r[4*d +: 4] = (neg && v != 0) ? 4'hA : 4'hF;
        return r;
    endfunction

    // Model: m_cnt counts the edges remaining until the result is committed.
    int          m_cnt[2], m_val[2], m_off[2];
    bit          m_neg[2], m_done[2];
    logic [23:0] m_bcd[2];

    always @(posedge clk or posedge rst) begin
        for (int j = 0; j < 2; j++) begin
            if (rst) begin
                m_cnt[j]  <= 0;
                m_done[j] <= 1'b0;
                m_off[j]  <= 0;
                m_bcd[j]  <= to_bcd(0, 1'b0, DG[j]);
            end else begin
                m_done[j] <= 1'b0;
                if (m_cnt[j] == 0) begin
                    if (st[j]) begin
                        m_cnt[j] <= BW[j] + 1;
                        m_val[j] <= (j == 0) ? int'(bin_a) : int'(bin_b);
                        m_neg[j] <= ng[j];
                    end
                end else begin
                    m_cnt[j] <= m_cnt[j] - 1;
                    if (m_cnt[j] == 1) begin
                        m_bcd[j]  <= to_bcd(m_val[j], m_neg[j], DG[j]);
                        m_done[j] <= 1'b1;
                    end
                end
                if (up[j] && !dn[j] && m_off[j] < MO[j]) m_off[j] <= m_off[j] + 1;
                else if (dn[j] && !up[j] && m_off[j] > 0) m_off[j] <= m_off[j] - 1;
            end
        end
    end

    logic [23:0] c_bcd;
    logic [15:0] c_disp, e_disp;
    logic [1:0]  c_off;
    logic        c_busy, c_done;

    always @(negedge clk) begin
        if (!rst) begin
            for (int j = 0; j < 2; j++) begin
                c_bcd  = (j == 0) ? bcd_a : {8'h0, bcd_b};
                c_disp = (j == 0) ? disp_a : {8'h0, disp_b};
                c_off  = (j == 0) ? off_a : off_b;
                c_busy = (j == 0) ? busy_a : busy_b;
                c_done = (j == 0) ? done_a : done_b;
                e_disp = '0;
                for (int i = 0; i < DD[j]; i++) begin
                    e_disp[4*i +: 4] = m_bcd[j][4*(m_off[j] + i) +: 4];
                end
                check(j == 0 ? "bcd16" : "bcd8", 32'(c_bcd), 32'(m_bcd[j]));
                check(j == 0 ? "disp16" : "disp8", 32'(c_disp), 32'(e_disp));
                check(j == 0 ? "off16" : "off8", 32'(c_off), 32'(m_off[j]));
                check(j == 0 ? "busy16" : "busy8", 32'(c_busy), 32'(m_cnt[j] != 0));
                check(j == 0 ? "done16" : "done8", 32'(c_done), 32'(m_done[j]));
                if (c_done) dcount[j]++;
            end
        end
    end

    task automatic convert(input int j, input int v, input bit n, input bit rs);
        int k;
        if (j == 0) bin_a = 16'(v);
        else bin_b = 8'(v);
        ng[j] = n;
        st[j] = 1'b1;
        @(negedge clk);
        st[j] = 1'b0;
        k = 1;
        while (!((j == 0) ? done_a : done_b) && k < 60) begin
            if (rs) begin
                up[j] = ($urandom_range(0, 3) == 0);
                dn[j] = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            k++;
        end
        up[j] = 1'b0;
        dn[j] = 1'b0;
        check(j == 0 ? "latency16" : "latency8", 32'(k - 1), 32'(BW[j] + 1));
    endtask

    task automatic pulse(input int j, input bit u, input bit d);
        up[j] = u;
        dn[j] = d;
        @(negedge clk);
        up[j] = 1'b0;
        dn[j] = 1'b0;
    endtask

    initial begin
        int d0;
        #2 rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_bcd16", 32'(bcd_a), 32'h00F00000);
        check("rst_bcd8", 32'(bcd_b), 32'h0000F000);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_off", 32'(off_a), 32'h0);

        convert(0, 0, 1'b1, 1'b0);
        check("neg_zero", 32'(bcd_a), 32'h00F00000);

        convert(0, 65535, 1'b0, 1'b0);
        check("max_bcd", 32'(bcd_a), 32'h00F65535);
        check("max_disp", 32'(disp_a), 32'h00005535);

        convert(0, 12345, 1'b1, 1'b0);
        repeat (3) pulse(0, 1'b1, 1'b0);
        check("sat_off", 32'(off_a), 32'h2);
        check("sat_disp", 32'(disp_a), 32'h0000A123);
        pulse(0, 1'b1, 1'b1);
        check("both_off", 32'(off_a), 32'h2);
        repeat (3) pulse(0, 1'b0, 1'b1);
        check("floor_disp", 32'(disp_a), 32'h00002345);

        // Start held high for 54 edges: accepted at edges 0, 18, 36 only.
        #1 d0 = dcount[0];
        st[0] = 1'b1;
        for (int c = 0; c < 54; c++) begin
            bin_a = 16'($urandom);
            ng[0] = 1'($urandom);
            @(negedge clk);
        end
        st[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1 check("burst_dones", 32'(dcount[0] - d0), 32'd3);

        repeat (30) convert(0, int'($urandom_range(0, 65535)), 1'($urandom), 1'b1);

        // Reset after eight of sixteen shifts.
        bin_a = 16'd12345;
        ng[0] = 1'b1;
        st[0] = 1'b1;
        @(negedge clk);
        st[0] = 1'b0;
        repeat (8) @(negedge clk);
        #1 d0 = dcount[0];
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy_a), 32'h0);
        check("abort_bcd", 32'(bcd_a), 32'h00F00000);
        check("abort_done", 32'(done_a), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #1 check("abort_nodone", 32'(dcount[0] - d0), 32'd0);
        convert(0, 999, 1'b0, 1'b0);
        check("after_abort", 32'(bcd_a), 32'h00F00999);

        for (int v = 0; v < 256; v++) begin
            convert(1, v, 1'b0, 1'b1);
            convert(1, v, 1'b1, 1'b1);
        end
        check("b8_last", 32'(bcd_b), 32'h0000A255);
        repeat (3) pulse(1, 1'b0, 1'b1);
        check("b8_off0", 32'(disp_b), 32'h55);
        pulse(1, 1'b1, 1'b0);
        check("b8_off1", 32'(disp_b), 32'h25);
        pulse(1, 1'b1, 1'b0);
        check("b8_off2", 32'(disp_b), 32'hA2);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
